rr_reg_arbiter: RTL and testbench

Round-robin write arbiter that shares one DATA_W-wide async-reset storage register among NUM_REQ requesters. Each requester raises a request with its write data. The arbiter grants one requester at a time, commits that requester's data into the shared register, and returns a one-cycle acknowledge. It sits between independent producer blocks and the shared register, and is the only path by which that register is written.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 36 +++
 rtl/rr_reg_arbiter.sv | 116 +++++++++++
 tb/tb_rr_reg_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state encodings and a clog2 helper.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_e;

    // Ceiling log2, never below 1 so a pointer always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [PTR_W-1:0]   win_idx,
    output logic               any
);

    // Scan offsets 0..NUM_REQ-1 from ptr; the wrap is explicit so
    // non-power-of-two requester counts behave.
    always_comb begin
        int s;
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        s       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            s = int'(ptr) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any && (s == i) && req[i]) begin
                    any       = 1'b1;
                    win_oh[i] = 1'b1;
                    win_idx   = PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin write arbiter in front of one shared DATA_W register.
// Each transaction is IDLE -> GRANT -> ACK, three cycles long.
module rr_reg_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         q,
    output logic                      busy
);

    localparam int PTR_W = clog2(NUM_REQ);

    arb_state_e           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q,   ptr_d;
    logic [PTR_W-1:0]     idx_q,   idx_d;
    logic [NUM_REQ-1:0]   gnt_q,   gnt_d;
    logic [NUM_REQ-1:0]   ack_q,   ack_d;
    logic [DATA_W-1:0]    hold_q,  hold_d;
    logic [DATA_W-1:0]    q_q,     q_d;
    logic                 busy_q,  busy_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // Next-state and output decode; data is captured at grant time so a
    // winner dropping req mid-transaction still completes its write.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        hold_d  = hold_q;
        q_d     = q_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_oh;
                    idx_d   = pick_idx;
                    busy_d  = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_oh[i]) hold_d = wdata[i*DATA_W +: DATA_W];
                    end
                end
            end
            ST_GRANT: begin
                state_d = ST_ACK;
                q_d     = hold_q;
                ack_d   = gnt_q;
                if (int'(idx_q) == NUM_REQ - 1) ptr_d = '0;
                else                            ptr_d = idx_q + PTR_W'(1);
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, pointer and data registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            hold_q  <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            hold_q  <= hold_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign q    = q_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: vector table plus hand sequences, with an ack scoreboard.
module tb_rr_reg_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt, ack;
    logic [7:0]  q;
    logic        busy;

    logic [2:0]  req3;
    logic [23:0] wdata3;
    logic [2:0]  gnt3, ack3;
    logic [7:0]  q3;
    logic        busy3;

    rr_reg_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .q(q), .busy(busy)
    );

    rr_reg_arbiter #(.NUM_REQ(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .wdata(wdata3),
        .gnt(gnt3), .ack(ack3), .q(q3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] data;
    } sb_t;
    sb_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] d);
        sb_t e;
        e.ack  = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every ack pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && ack != 4'b0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", {28'b0, ack}, 32'h0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("sb_ack", {28'b0, ack}, {28'b0, e.ack});
                chk("sb_q", {24'b0, q}, {24'b0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [7:0]  data;
    } vec_t;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] wdata;
        logic [2:0]  gnt;
        logic [7:0]  data;
    } vec3_t;

    vec_t  vt[7];
    vec3_t vt3[5];

    initial begin
        // Expected winners follow from the pointer left by each previous row.
        vt[0] = '{4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5}; // ptr 0 -> 3
        vt[1] = '{4'b1001, 32'h3300_0030, 4'b1000, 8'h33}; // ptr 3 -> 0
        vt[2] = '{4'b1001, 32'h3300_0030, 4'b0001, 8'h30}; // ptr 0 -> 1
        vt[3] = '{4'b0001, 32'h0000_0077, 4'b0001, 8'h77}; // wraps, ptr 1
        vt[4] = '{4'b0110, 32'h0062_6100, 4'b0010, 8'h61}; // ptr 1 -> 2
        vt[5] = '{4'b0011, 32'h0000_8180, 4'b0001, 8'h80}; // 2,3,0 -> ptr 1
        vt[6] = '{4'b1000, 32'hFF00_0000, 4'b1000, 8'hFF}; // ptr -> 0

        vt3[0] = '{3'b100, 24'hC2B1A0, 3'b100, 8'hC2}; // ptr wraps 2 -> 0
        vt3[1] = '{3'b011, 24'hC2B1A0, 3'b001, 8'hA0}; // ptr -> 1
        vt3[2] = '{3'b101, 24'hC2B1A0, 3'b100, 8'hC2}; // ptr -> 0
        vt3[3] = '{3'b101, 24'hC2B1A0, 3'b001, 8'hA0}; // ptr -> 1
        vt3[4] = '{3'b110, 24'hC2B1A0, 3'b010, 8'hB1}; // ptr -> 2

        rst = 1'b0; req = '0; wdata = '0; req3 = '0; wdata3 = '0;

        // Async reset asserted mid-clock for 12 ns.
        #2 rst = 1'b1;
        #1;
        chk("rst_gnt",  {28'b0, gnt}, 32'h0);
        chk("rst_ack",  {28'b0, ack}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_q",    {24'b0, q}, 32'h0);
        #11 rst = 1'b0;
        tick();
        chk("idle_busy", {31'b0, busy}, 32'h0);

        // Table-driven single transactions.
        foreach (vt[i]) begin
            req = vt[i].req; wdata = vt[i].wdata;
            tick();
            chk($sformatf("v%0d_gnt", i), {28'b0, gnt}, {28'b0, vt[i].gnt});
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'h1);
            push(vt[i].gnt, vt[i].data);
            req = '0;
            tick();
            chk($sformatf("v%0d_q", i), {24'b0, q}, {24'b0, vt[i].data});
            tick();
            chk($sformatf("v%0d_done", i), {27'b0, busy, gnt}, 32'h0);
        end

        // All four requesting continuously: 0,1,2,3,0, one every 3 cycles.
        req = 4'b1111; wdata = 32'h1312_1110;
        push(4'b0001, 8'h10); push(4'b0010, 8'h11); push(4'b0100, 8'h12);
        push(4'b1000, 8'h13); push(4'b0001, 8'h10);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("all_gnt%0d", i), {28'b0, gnt}, 32'h1 << (i % 4));
            tick();
            tick();
        end
        req = '0;

        // Early drop: winner 1 releases right after grant; 0 waits and goes next.
        req = 4'b0011; wdata = 32'h0000_5544;
        tick();
        chk("drop_gnt1", {28'b0, gnt}, 32'h2);
        req = 4'b0001;
        push(4'b0010, 8'h55); push(4'b0001, 8'h44);
        tick(); tick();
        tick();
        chk("drop_gnt0", {28'b0, gnt}, 32'h1);
        req = '0;
        tick(); tick();
        chk("drop_idle", {31'b0, busy}, 32'h0);

        // Reset during GRANT: no ack, q cleared, fresh grant after release.
        req = 4'b0010; wdata = 32'h0000_5A00;
        tick();
        chk("mid_gnt", {28'b0, gnt}, 32'h2);
        rst = 1'b1;
        #1;
        chk("mid_rst_q",    {24'b0, q}, 32'h0);
        chk("mid_rst_gnt",  {28'b0, gnt}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        #11 rst = 1'b0;
        chk("mid_rst_q_held", {24'b0, q}, 32'h0);
        push(4'b0010, 8'h5A);
        tick();
        chk("mid_regnt", {28'b0, gnt}, 32'h2);
        req = '0;
        tick();
        chk("mid_q", {24'b0, q}, 32'h5A);
        tick();
        chk("mid_done", {31'b0, busy}, 32'h0);

        // Non-power-of-two requester count.
        foreach (vt3[i]) begin
            req3 = vt3[i].req; wdata3 = vt3[i].wdata;
            tick();
            chk($sformatf("n3_%0d_gnt", i), {29'b0, gnt3}, {29'b0, vt3[i].gnt});
            req3 = '0;
            tick();
            chk($sformatf("n3_%0d_ack", i), {29'b0, ack3}, {29'b0, vt3[i].gnt});
            chk($sformatf("n3_%0d_q", i), {24'b0, q3}, {24'b0, vt3[i].data});
            tick();
            chk($sformatf("n3_%0d_done", i), {28'b0, busy3, ack3}, 32'h0);
        end

        tick();
        chk("sb_empty", sb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
